// File: rtl/mc_cr_pkg.sv
// Shared constants and state type for the chroma MC bilinear interpolator.
package mc_cr_pkg;
  localparam int PIX_W_DEFAULT = 8;
  localparam int CR_BLK = 4;
  localparam int CR_REF = 5;
  localparam int W_W = 7;
  localparam int ACC_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROWS  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mc_cr_state_t;
endpackage

// File: rtl/mc_cr_bilin4.sv
// Combinational 1/8-pel bilinear filter producing one 4-sample predicted row
// from two 5-sample reference rows.
module mc_cr_bilin4
  import mc_cr_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic [CR_REF*PIX_W-1:0] top,
  input  logic [CR_REF*PIX_W-1:0] bot,
  input  logic [2:0]              dx,
  input  logic [2:0]              dy,
  output logic [CR_BLK*PIX_W-1:0] pred
);
  // Weights sum to 64, so the sum never exceeds 64*max_sample + 32.
  localparam int AW = (W_W + PIX_W > ACC_W) ? (W_W + PIX_W) : ACC_W;

  logic [W_W-1:0] ex, ey, wa, wb, wc, wd;
  logic [AW-1:0]  acc;

  always_comb begin
    ex   = W_W'(8) - W_W'(dx);
    ey   = W_W'(8) - W_W'(dy);
    wa   = ex * ey;
    wb   = W_W'(dx) * ey;
    wc   = ex * W_W'(dy);
    wd   = W_W'(dx) * W_W'(dy);
    acc  = '0;
    pred = '0;
    for (int x = 0; x < CR_BLK; x++) begin
      acc = AW'(wa) * AW'(top[x*PIX_W +: PIX_W])
          + AW'(wb) * AW'(top[(x+1)*PIX_W +: PIX_W])
          + AW'(wc) * AW'(bot[x*PIX_W +: PIX_W])
          + AW'(wd) * AW'(bot[(x+1)*PIX_W +: PIX_W])
          + AW'(32);
      pred[x*PIX_W +: PIX_W] = PIX_W'(acc >> 6);
    end
  end
endmodule

// File: rtl/mc_cr_interp.sv
// Chroma MC interpolator: takes 5 reference rows per 4x4 block and emits 4
// bilinear-filtered predicted rows through a registered dst stage.
module mc_cr_interp
  import mc_cr_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              frac_dx,
  input  logic [2:0]              frac_dy,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [CR_REF*PIX_W-1:0] src_data,
  output logic                    dst_valid,
  input  logic                    dst_ready,
  output logic [CR_BLK*PIX_W-1:0] dst_data,
  output logic                    blk_done,
  output logic                    busy,
  output mc_cr_state_t            dbg_state
);
  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // sender holds data stable while valid && !ready and never retracts valid.

  mc_cr_state_t            state, next_state;
  logic [2:0]              row_cnt;
  logic [CR_REF*PIX_W-1:0] prev_row;
  logic [2:0]              fdx, fdy;
  logic [CR_BLK*PIX_W-1:0] pred;
  logic                    src_fire;

  mc_cr_bilin4 #(.PIX_W(PIX_W)) u_bilin (
    .top  (prev_row),
    .bot  (src_data),
    .dx   (fdx),
    .dy   (fdy),
    .pred (pred)
  );

  assign src_fire  = src_valid && src_ready;
  assign blk_done  = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    src_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        src_ready = 1'b1;
        if (src_valid) next_state = ROWS;
      end
      ROWS: begin
        // Stall the source whenever the output register cannot be refilled.
        src_ready = !dst_valid || dst_ready;
        if (src_valid && (!dst_valid || dst_ready) && row_cnt == 3'(CR_BLK))
          next_state = DRAIN;
      end
      DRAIN: if (dst_valid && dst_ready) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (reset) src_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row_cnt   <= 3'd0;
      prev_row  <= '0;
      fdx       <= 3'd0;
      fdy       <= 3'd0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
    end else begin
      state <= next_state;
      if (src_fire) prev_row <= src_data;

      if (state == IDLE && src_fire) begin
        fdx     <= frac_dx;
        fdy     <= frac_dy;
        row_cnt <= 3'd1;
      end else if (state == ROWS && src_fire) begin
        row_cnt <= row_cnt + 3'd1;
      end else if (state == DONE) begin
        row_cnt <= 3'd0;
      end

      // A new row loading wins over retiring the old one in the same cycle.
      if (state == ROWS && src_fire) begin
        dst_data  <= pred;
        dst_valid <= 1'b1;
      end else if (dst_valid && dst_ready) begin
        dst_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mc_cr_interp.sv
// Directed, table-driven bench for mc_cr_interp with a row scoreboard.
module tb_mc_cr_interp;
  import mc_cr_pkg::*;

  typedef struct packed {
    logic [2:0]       dx;
    logic [2:0]       dy;
    logic [4:0][39:0] rows;
    logic [3:0][31:0] exp_rows;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   frac_dx = 3'd0;
  logic [2:0]   frac_dy = 3'd0;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic [39:0]  src_data = '0;
  logic         dst_valid;
  logic         dst_ready = 1'b1;
  logic [31:0]  dst_data;
  logic         blk_done;
  logic         busy;
  mc_cr_state_t dbg_state;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;

  mc_cr_interp #(.PIX_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .frac_dx   (frac_dx),
    .frac_dy   (frac_dy),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .dst_data  (dst_data),
    .blk_done  (blk_done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [39:0] p5(input int a, input int b, input int c, input int d, input int e);
    return {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (blk_done === 1'b1) done_cnt++;
    if (dst_valid === 1'b1 && dst_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_row: got %0h expected none at %0t", dst_data, $time);
      end else begin
        check("dst_row", {32'd0, dst_data}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_row(input logic [39:0] d, input logic [2:0] fx, input logic [2:0] fy);
    int n = 0;
    src_valid = 1'b1;
    src_data  = d;
    frac_dx   = fx;
    frac_dy   = fy;
    @(negedge clk);
    while (src_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (src_ready !== 1'b1) check("src_accept_timeout", {63'd0, src_ready}, 64'd1);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask

  // Fractions are only valid on row 0; later rows carry inverted garbage.
  task automatic run_block(input int v);
    int d0;
    d0 = done_cnt;
    for (int r = 0; r < 4; r++) exp_q.push_back(vecs[v].exp_rows[r]);
    for (int r = 0; r < 5; r++)
      send_row(vecs[v].rows[r], (r == 0) ? vecs[v].dx : ~vecs[v].dx,
               (r == 0) ? vecs[v].dy : ~vecs[v].dy);
    @(negedge clk);
    check("drain_no_done", {63'd0, blk_done}, 64'd0);
    @(negedge clk);
    check("done_pulse", {63'd0, blk_done}, 64'd1);
    @(posedge clk);
    #1;
    check("rows_all_seen", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(d0 + 1));
  endtask

  // ---------------- test ----------------
  initial begin
    int d0;
    int n;

    // Vector table (expected values hand-derived from the filter formula).
    for (int v = 0; v < 6; v++) vecs[v] = '0;
    vecs[0].dx = 3'd0; vecs[0].dy = 3'd0;
    for (int r = 0; r < 5; r++) vecs[0].rows[r] = p5(10*r, 10*r+1, 10*r+2, 10*r+3, 10*r+4);
    for (int r = 0; r < 4; r++) vecs[0].exp_rows[r] = p4(10*r, 10*r+1, 10*r+2, 10*r+3);
    vecs[1].dx = 3'd4; vecs[1].dy = 3'd0;
    for (int r = 0; r < 5; r++) vecs[1].rows[r] = p5(10, 20, 10, 20, 10);
    for (int r = 0; r < 4; r++) vecs[1].exp_rows[r] = p4(15, 15, 15, 15);
    vecs[2].dx = 3'd1; vecs[2].dy = 3'd0;
    for (int r = 0; r < 5; r++) vecs[2].rows[r] = p5(0, 4, 0, 4, 0);
    for (int r = 0; r < 4; r++) vecs[2].exp_rows[r] = p4(1, 4, 1, 4);
    vecs[3].dx = 3'd7; vecs[3].dy = 3'd7;
    for (int r = 0; r < 5; r++) vecs[3].rows[r] = p5(255, 255, 255, 255, 255);
    for (int r = 0; r < 4; r++) vecs[3].exp_rows[r] = p4(255, 255, 255, 255);
    vecs[4].dx = 3'd3; vecs[4].dy = 3'd5;
    for (int r = 0; r < 5; r++) vecs[4].rows[r] = p5(0, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) vecs[4].exp_rows[r] = p4(0, 0, 0, 0);
    // dx=2, dy=6 on a ramp 8r+4x: weights 12/4/36/12 give 8r+4x+7.
    vecs[5].dx = 3'd2; vecs[5].dy = 3'd6;
    for (int r = 0; r < 5; r++) vecs[5].rows[r] = p5(8*r, 8*r+4, 8*r+8, 8*r+12, 8*r+16);
    for (int r = 0; r < 4; r++) vecs[5].exp_rows[r] = p4(8*r+7, 8*r+11, 8*r+15, 8*r+19);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("src_ready_in_reset", {63'd0, src_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_src_ready", {63'd0, src_ready}, 64'd1);
    check("rst_dst_valid", {63'd0, dst_valid}, 64'd0);
    check("rst_dst_data", {32'd0, dst_data}, 64'd0);
    check("rst_blk_done", {63'd0, blk_done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    @(posedge clk);
    #1;

    // Table-driven full blocks.
    for (int v = 0; v < 6; v++) run_block(v);

    // Backpressure: hold dst_ready low for 3 cycles once the first row is out.
    dst_ready = 1'b0;
    fork
      run_block(0);
      begin
        n = 0;
        @(negedge clk);
        while (dst_valid !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("bp_first_valid", {63'd0, dst_valid}, 64'd1);
        for (int k = 0; k < 3; k++) begin
          check("bp_src_ready", {63'd0, src_ready}, 64'd0);
          check("bp_dst_valid", {63'd0, dst_valid}, 64'd1);
          check("bp_data_stable", {32'd0, dst_data}, {32'd0, vecs[0].exp_rows[0]});
          if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        dst_ready = 1'b1;
      end
    join

    // Reset mid-block after row 2 is accepted.
    d0 = done_cnt;
    exp_q.push_back(vecs[5].exp_rows[0]);
    exp_q.push_back(vecs[5].exp_rows[1]);
    send_row(vecs[5].rows[0], vecs[5].dx, vecs[5].dy);
    send_row(vecs[5].rows[1], ~vecs[5].dx, ~vecs[5].dy);
    send_row(vecs[5].rows[2], ~vecs[5].dx, ~vecs[5].dy);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_dst_valid", {63'd0, dst_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_src_ready", {63'd0, src_ready}, 64'd1);
    check("mid_rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
    check("mid_rst_rows", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    @(posedge clk);
    #1;

    // Fresh block after the aborted one must carry no stale state.
    run_block(5);
    check("total_blocks", 64'(done_cnt), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
